led_cnt_sequencer: RTL and testbench
====================================

// Module: led_cnt_sequencer
// PURPOSE
//  Synchronous command sequencer for the 10-bit LED counter datapath.
//  Takes debounced button levels and a run/step mode, detects edges, and queues requests.
//  Arbitrates the requests by fixed priority and issues one opcode at a time over a valid/ready handshake.
//  Its internal prescaler replaces the derived ripple clock; everything runs on CLK.
// PARAMETERS
//  TICK_DIV  4194304  CLK cycles per auto-step tick; legal values >= 2
//  CNT_W     23       prescaler width; must hold TICK_DIV-1
// PORTS
//  CLK        in   1  system clock; all logic on posedge CLK
//  RST        in   1  reset, synchronous, active-high
//  CLR_REQ    in   1  debounced level; rising edge requests counter clear
//  LD2AA_REQ  in   1  debounced level; rising edge requests load of 10'h2AA
//  LD155_REQ  in   1  debounced level; rising edge requests load of 10'h155
//  STEP_REQ   in   1  debounced level; rising edge requests one step while RUN=0
//  RUN        in   1  level; 1 = auto-step on TICK, 0 = manual step
//  MODE_SHR   in   1  level; step op is shift-left
//  MODE_SUB   in   1  level; step op is decrement (MODE_SHR wins)
//  OP_READY   in   1  datapath accepts OP this cycle
//  OP_VALID   out  1  OP is valid
//  OP         out  3  0 INC, 1 DEC, 2 SHL, 3 LD2AA, 4 LD155, 5 CLR
//  TICK       out  1  one-cycle prescaler pulse (activity LED source)
//  PENDING    out  4  {clr, ld2aa, ld155, step} pending bits
//  OVR        out  1  sticky: a step request was merged into one already pending
// BEHAVIOUR
//  Reset:
//   - OP_VALID=0, OP=0, TICK=0, PENDING=0, OVR=0, prescaler=0, FSM=IDLE.
//   - Edge-history registers are set to 1, so inputs held high across reset release do not fire.
//   - Reset mid-handshake drops the in-flight op; no accept is implied.
//  Edge detect: req_edge = level & ~level_q; one-cycle latency from input to PENDING.
//  Step source:
//   - RUN=0: STEP_REQ edge sets pend_step.
//   - RUN=1: TICK sets pend_step; STEP_REQ is ignored.
//  Pending bits:
//   - An edge sets its bit.
//   - A handshake (OP_VALID & OP_READY) clears the bit of the issued op.
//   - Edge and clear of the same bit in the same cycle: the set wins, so the request is retained.
//   - Edge while the bit is already set: merged. For step only, OVR<=1 and stays set until RST.
//  Prescaler:
//   - Counts 0..TICK_DIV-1 continuously, independent of RUN and the handshake.
//   - TICK=1 in the cycle after the count wraps to 0.
//  FSM, two states:
//   - IDLE: if PENDING!=0, latch OP by priority CLR > LD2AA > LD155 > STEP, then go to ISSUE.
//   - IDLE: OP_VALID=1 from the next cycle.
//   - ISSUE: OP_VALID=1; OP and OP_VALID are held stable until OP_READY=1.
//   - ISSUE, on accept: clear the pending bit, go to IDLE, OP_VALID=0.
//   - ISSUE: higher-priority requests arriving here never preempt.
//   - Throughput: at most one op per 2 cycles. Latency from edge to OP_VALID is 2 cycles when IDLE and empty.
//  Step opcode:
//   - Resolved at latch time: MODE_SHR ? SHL : MODE_SUB ? DEC : INC.
//   - Mode changes during ISSUE do not alter OP.
//  RUN toggling does not reset the prescaler or clear pend_step.
// TESTING (TICK_DIV=4)
//  - RST high 3 cycles with CLR_REQ held 1, then release -> no op issued, PENDING=0, OVR=0.
//  - OP_READY tied 1, RUN=0, STEP_REQ pulse -> OP_VALID exactly 2 cycles later for 1 cycle.
//    * OP=0, with MODE_SHR=MODE_SUB=0.
//    * OP=2, with MODE_SHR=1, MODE_SUB=1.
//  - OP_READY=0; pulse LD155_REQ, then CLR_REQ and LD2AA_REQ.
//    * OP=4 is held valid until ready.
//    * Raising ready then yields OP=5, then OP=3, each 2 cycles apart.
//  - RUN=1, OP_READY=1, MODE_SUB=1 -> TICK every 4 cycles, OP=1 issued once per TICK, OVR stays 0.
//  - RUN=1, OP_READY=0 for 12 cycles -> single step pending, OVR=1; ready -> exactly one OP=1.
//  - Assert RST while OP_VALID=1 and OP_READY=0 -> OP_VALID=0 next cycle, PENDING=0.

Source files
------------

// File: rtl/led_cnt_sequencer.sv
// Command sequencer for the 10-bit LED counter datapath: edge-detects button levels,
// queues requests as pending bits and issues one opcode at a time over valid/ready.
module led_cnt_sequencer #(
   parameter int TICK_DIV = 4194304,
   parameter int CNT_W    = 23
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CLR_REQ,
   input  logic       LD2AA_REQ,
   input  logic       LD155_REQ,
   input  logic       STEP_REQ,
   input  logic       RUN,
   input  logic       MODE_SHR,
   input  logic       MODE_SUB,
   input  logic       OP_READY,
   output logic       OP_VALID,
   output logic [2:0] OP,
   output logic       TICK,
   output logic [3:0] PENDING,
   output logic       OVR
);

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef enum logic [2:0] {
      OP_INC   = 3'd0,
      OP_DEC   = 3'd1,
      OP_SHL   = 3'd2,
      OP_LD2AA = 3'd3,
      OP_LD155 = 3'd4,
      OP_CLR   = 3'd5
   } op_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   state_t           state, state_n;
   op_t              op_q, op_n;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       lvl, lvl_q, req_edge, set_bits, clr_bits;
   logic             accept;

   assign lvl      = {CLR_REQ, LD2AA_REQ, LD155_REQ, STEP_REQ};
   assign req_edge = lvl & ~lvl_q;
   assign set_bits = {req_edge[3:1], RUN ? TICK : req_edge[0]};
   assign OP_VALID = (state == ISSUE);
   assign OP       = op_q;
   assign accept   = OP_VALID & OP_READY;

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt  <= '0;
         TICK <= 1'b0;
      end else begin
         cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
         TICK <= (cnt == CNT_LAST);
      end
   end

   // Accepted op retires its own pending bit; all step flavours share bit 0.
   always_comb begin
      clr_bits = 4'b0000;
      if (accept) begin
         unique case (op_q)
            OP_CLR:   clr_bits = 4'b1000;
            OP_LD2AA: clr_bits = 4'b0100;
            OP_LD155: clr_bits = 4'b0010;
            default:  clr_bits = 4'b0001;
         endcase
      end
   end

   // History resets high so a level already asserted at reset release is not an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lvl_q   <= 4'b1111;
         PENDING <= 4'b0000;
         OVR     <= 1'b0;
      end else begin
         lvl_q   <= lvl;
         PENDING <= (PENDING & ~clr_bits) | set_bits;
         if (set_bits[0] & PENDING[0] & ~clr_bits[0])
            OVR <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         op_q  <= OP_INC;
      end else begin
         state <= state_n;
         op_q  <= op_n;
      end
   end

   // Opcode, including the step flavour, is frozen at latch time and held through ISSUE.
   always_comb begin
      state_n = state;
      op_n    = op_q;
      unique case (state)
         IDLE: begin
            if (PENDING != 4'b0000) begin
               state_n = ISSUE;
               if (PENDING[3])      op_n = OP_CLR;
               else if (PENDING[2]) op_n = OP_LD2AA;
               else if (PENDING[1]) op_n = OP_LD155;
               else if (MODE_SHR)   op_n = OP_SHL;
               else if (MODE_SUB)   op_n = OP_DEC;
               else                 op_n = OP_INC;
            end
         end
         ISSUE: begin
            if (OP_READY)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_led_cnt_sequencer.sv
// Self-checking bench for led_cnt_sequencer: directed scenarios plus random traffic,
// compared every cycle against a request-queue reference model.
module tb_led_cnt_sequencer;

   localparam int TICK_DIV = 4;
   localparam int CNT_W    = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       CLR_REQ = 1'b0, LD2AA_REQ = 1'b0, LD155_REQ = 1'b0, STEP_REQ = 1'b0;
   logic       RUN = 1'b0, MODE_SHR = 1'b0, MODE_SUB = 1'b0, OP_READY = 1'b0;
   logic       OP_VALID, TICK, OVR;
   logic [2:0] OP;
   logic [3:0] PENDING;

   int checks = 0;
   int errors = 0;

   // Reference state: index 0 step, 1 ld155, 2 ld2aa, 3 clr.
   bit m_prev[4];
   bit m_pend[4];
   bit m_valid;
   int m_op;
   bit m_ovr;
   bit m_tick;
   int m_cyc;

   led_cnt_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST),
      .CLR_REQ(CLR_REQ), .LD2AA_REQ(LD2AA_REQ), .LD155_REQ(LD155_REQ), .STEP_REQ(STEP_REQ),
      .RUN(RUN), .MODE_SHR(MODE_SHR), .MODE_SUB(MODE_SUB), .OP_READY(OP_READY),
      .OP_VALID(OP_VALID), .OP(OP), .TICK(TICK), .PENDING(PENDING), .OVR(OVR)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, observed, expected, m_cyc);
      end
   endtask

   function automatic int pendVec();
      return (m_pend[3] ? 8 : 0) + (m_pend[2] ? 4 : 0) + (m_pend[1] ? 2 : 0) + (m_pend[0] ? 1 : 0);
   endfunction

   // Advance the reference by one clock using the inputs that the DUT just sampled.
   task automatic modelStep();
      bit lv[4];
      bit set[4];
      bit accept;
      int clr_idx;
      int hi;
      if (RST) begin
         for (int i = 0; i < 4; i++) begin
            m_prev[i] = 1'b1;
            m_pend[i] = 1'b0;
         end
         m_valid = 1'b0;
         m_op    = 0;
         m_ovr   = 1'b0;
         m_tick  = 1'b0;
         m_cyc   = 0;
      end else begin
         lv = '{STEP_REQ, LD155_REQ, LD2AA_REQ, CLR_REQ};
         accept = m_valid && OP_READY;
         for (int i = 0; i < 4; i++) set[i] = lv[i] && !m_prev[i];
         if (RUN) set[0] = m_tick;
         clr_idx = -1;
         if (accept) clr_idx = (m_op == 5) ? 3 : (m_op == 3) ? 2 : (m_op == 4) ? 1 : 0;
         if (set[0] && m_pend[0] && clr_idx != 0) m_ovr = 1'b1;
         hi = -1;
         for (int i = 0; i < 4; i++) if (m_pend[i]) hi = i;
         if (m_valid) begin
            if (accept) m_valid = 1'b0;
         end else if (hi >= 0) begin
            m_valid = 1'b1;
            case (hi)
               3:       m_op = 5;
               2:       m_op = 3;
               1:       m_op = 4;
               default: m_op = MODE_SHR ? 2 : (MODE_SUB ? 1 : 0);
            endcase
         end
         for (int i = 0; i < 4; i++) m_pend[i] = (m_pend[i] && i != clr_idx) || set[i];
         m_prev = lv;
         m_cyc++;
         m_tick = (m_cyc % TICK_DIV) == 0;
      end
   endtask

   // req = {clr, ld2aa, ld155, step}
   task automatic applyStimulus(input logic rst_v, input logic [3:0] req, input logic run_v,
                                input logic shr_v, input logic sub_v, input logic rdy_v);
      @(negedge CLK);
      RST       = rst_v;
      CLR_REQ   = req[3];
      LD2AA_REQ = req[2];
      LD155_REQ = req[1];
      STEP_REQ  = req[0];
      RUN       = run_v;
      MODE_SHR  = shr_v;
      MODE_SUB  = sub_v;
      OP_READY  = rdy_v;
      @(posedge CLK);
      modelStep();
      #1;
      checkOutput("op_valid", int'(OP_VALID), int'(m_valid));
      checkOutput("op", int'(OP), m_op);
      checkOutput("tick", int'(TICK), int'(m_tick));
      checkOutput("pending", int'(PENDING), pendVec());
      checkOutput("ovr", int'(OVR), int'(m_ovr));
   endtask

   initial begin
      logic [3:0] lv;
      logic       run_r, shr_r, sub_r;

      // Reset with CLR held high: release must not fire a clear.
      repeat (3) applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("rst_pending", int'(PENDING), 0);
      checkOutput("rst_ovr", int'(OVR), 0);
      repeat (4) applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("held_no_op", int'(OP_VALID), 0);
      checkOutput("held_no_pend", int'(PENDING), 0);
      applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Manual steps: INC then SHL (SHR wins over SUB).
      applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (4) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1);

      // Backpressure: LD155 held, then CLR and LD2AA drain by priority.
      applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1100, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (4) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("held_ld155", int'(OP), 4);
      repeat (8) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);

      // Auto-step with DEC, then a stalled auto-step that overruns.
      repeat (16) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("run_no_ovr", int'(OVR), 0);
      repeat (12) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("stall_ovr", int'(OVR), 1);
      repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);

      // Reset in the middle of a stalled handshake drops the op.
      repeat (2) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_valid", int'(OP_VALID), 1);
      applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_drop_valid", int'(OP_VALID), 0);
      checkOutput("rst_drop_pend", int'(PENDING), 0);

      // Random traffic with occasional resets.
      lv = 4'b0000;
      run_r = 1'b0;
      shr_r = 1'b0;
      sub_r = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(3) == 0) lv[b] = ~lv[b];
         if ($urandom_range(15) == 0) run_r = ~run_r;
         if ($urandom_range(7) == 0) shr_r = ~shr_r;
         if ($urandom_range(7) == 0) sub_r = ~sub_r;
         applyStimulus($urandom_range(79) == 0, lv, run_r, shr_r, sub_r, 1'($urandom_range(1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
